icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 122 ++++++++++++
 tb/tb_icache_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller, 16 lines x 4 words
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic {IDLE, REFILL} stateType;

    stateType    state;
    stateType    nextState;

    logic [31:0] dataArr [16][4];
    logic [23:0] tagArr  [16];
    logic [15:0] validArr;

    logic [1:0]  beatCnt;
    logic [23:0] fillTag;
    logic [3:0]  fillIndex;

    logic [1:0]  pcWord;
    logic [3:0]  pcIndex;
    logic [23:0] pcTag;
    logic [1:0]  unusedPcBits;

    logic        missStart;
    logic        beatAccept;
    logic        lastBeat;

    assign pcWord       = pc[3:2];
    assign pcIndex      = pc[7:4];
    assign pcTag        = pc[31:8];
    assign unusedPcBits = pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!hit) nextState = REFILL;
            REFILL:  if (lastBeat) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        hit         = validArr[pcIndex] && (tagArr[pcIndex] == pcTag);
        instruction = hit ? dataArr[pcIndex][pcWord] : 32'h0000_0000;
        missStart   = (state == IDLE) && !hit;
        beatAccept  = (state == REFILL) && mem_req && mem_ready;
        lastBeat    = beatAccept && (beatCnt == 2'd3);
    end

    // The target line is invalidated at the miss edge so a partial fill can never hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            beatCnt   <= 2'd0;
            fillTag   <= 24'd0;
            fillIndex <= 4'd0;
            validArr  <= 16'd0;
        end else if (missStart) begin
            mem_req            <= 1'b1;
            mem_addr           <= {pcTag, pcIndex, 4'b0000};
            beatCnt            <= 2'd0;
            fillTag            <= pcTag;
            fillIndex          <= pcIndex;
            validArr[pcIndex]  <= 1'b0;
        end else if (beatAccept) begin
            beatCnt <= beatCnt + 2'd1;
            if (lastBeat) begin
                mem_req             <= 1'b0;
                validArr[fillIndex] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beatAccept) begin
            dataArr[fillIndex][beatCnt] <= mem_rdata;
        end
        if (lastBeat) begin
            tagArr[fillIndex] <= fillTag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if ((state == IDLE) && hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (missStart && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed self-checking bench for icache_ctrl
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    icache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int b;
        logic [5:0] readyPat;

        rst       = 1'b1;
        pc        = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        // First miss on line 0x40
        rst = 1'b0;
        pc  = 32'h0000_0040;
        #1;
        chk("miss_hit", {31'd0, hit}, 32'd0);
        chk("miss_instr", instruction, 32'd0);
        tick();
        chk("miss_req", {31'd0, mem_req}, 32'd1);
        chk("miss_addr", mem_addr, 32'h0000_0040);

        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'hA0 + i;
            tick();
            chk("fill_req", {31'd0, mem_req}, (i == 3) ? 32'd0 : 32'd1);
            chk("fill_hit", {31'd0, hit}, (i == 3) ? 32'd1 : 32'd0);
        end
        mem_ready = 1'b0;
        chk("fill_w0", instruction, 32'hA0);
        pc = 32'h0000_0048;
        #1;
        chk("fill_w2", instruction, 32'hA2);
        pc = 32'h0000_004C;
        #1;
        chk("fill_w3", instruction, 32'hA3);

        // Five-cycle penalty with mem_ready tied high; beat during mem_req=0 ignored
        mem_ready = 1'b1;
        pc        = 32'h0000_0080;
        mem_rdata = 32'hDEAD;
        #1;
        chk("pen_hit0", {31'd0, hit}, 32'd0);
        for (int t = 1; t <= 5; t++) begin
            if (t >= 2) mem_rdata = 32'hB0 + (t - 2);
            tick();
            chk("pen_hit", {31'd0, hit}, (t == 5) ? 32'd1 : 32'd0);
            if (t == 2) begin
                pc = 32'h0000_0048;
                #1;
                chk("pcchg_hit", {31'd0, hit}, 32'd1);
                chk("pcchg_instr", instruction, 32'hA2);
                chk("pcchg_addr", mem_addr, 32'h0000_0080);
                pc = 32'h0000_0080;
                #1;
            end
        end
        chk("pen_w0", instruction, 32'hB0);
        pc = 32'h0000_008C;
        #1;
        chk("pen_w3", instruction, 32'hB3);

        // Same index, new tag, with stalled beats
        mem_ready = 1'b0;
        pc        = 32'h0000_1040;
        #1;
        chk("alias_hit0", {31'd0, hit}, 32'd0);
        tick();
        chk("alias_addr", mem_addr, 32'h0000_1040);
        pc = 32'h0000_0040;
        #1;
        chk("alias_oldinv", {31'd0, hit}, 32'd0);
        pc = 32'h0000_1040;
        readyPat = 6'b110101;
        b = 0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = readyPat[i];
            mem_rdata = 32'hC0 + b;
            tick();
            if (readyPat[i]) b++;
            chk("stall_addr", mem_addr, 32'h0000_1040);
            chk("stall_hit", {31'd0, hit}, (b == 4) ? 32'd1 : 32'd0);
        end
        mem_ready = 1'b0;
        chk("stall_w0", instruction, 32'hC0);
        pc = 32'h0000_1044;
        #1;
        chk("stall_w1", instruction, 32'hC1);
        pc = 32'h0000_1048;
        #1;
        chk("stall_w2", instruction, 32'hC2);
        pc = 32'h0000_104C;
        #1;
        chk("stall_w3", instruction, 32'hC3);
        pc = 32'h0000_0040;
        #1;
        chk("evict_hit", {31'd0, hit}, 32'd0);
        tick();
        chk("evict_req", {31'd0, mem_req}, 32'd1);
        chk("evict_addr", mem_addr, 32'h0000_0040);

        // Reset after beat 1 abandons the refill
        mem_ready = 1'b1;
        mem_rdata = 32'hD0;
        tick();
        mem_rdata = 32'hD1;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("arst_hit", {31'd0, hit}, 32'd0);
        tick();
        chk("arst_req2", {31'd0, mem_req}, 32'd1);
        chk("arst_addr2", mem_addr, 32'h0000_0040);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'hE0 + i;
            tick();
            chk("refill_hit", {31'd0, hit}, (i == 3) ? 32'd1 : 32'd0);
        end
        mem_ready = 1'b0;
        pc = 32'h0000_0044;
        #1;
        chk("refill_w1", instruction, 32'hE1);

`ifdef ICACHE_STATS_EN
        rst = 1'b1;
        tick();
        chk("st_rst_hit", {16'd0, hit_count}, 32'd0);
        chk("st_rst_miss", {16'd0, miss_count}, 32'd0);
        rst       = 1'b0;
        pc        = 32'h0000_0040;
        mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'hF0 + i;
            tick();
        end
        chk("st_miss1", {16'd0, miss_count}, 32'd1);
        chk("st_hit0", {16'd0, hit_count}, 32'd0);
        repeat (3) tick();
        chk("st_hit3", {16'd0, hit_count}, 32'd3);
        repeat (65540) tick();
        chk("st_sat", {16'd0, hit_count}, 32'h0000_FFFF);
        chk("st_miss_hold", {16'd0, miss_count}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
